// File: rtl/sram_dp_sync.sv
`default_nettype none
// ============================================================================
// Module   : sram_dp_sync
// Brief    : Simple-dual-port synchronous SRAM with byte enables, 1/2-cycle
//            read latency and a post-reset zero-clear sequencer.
//            Optional macro SRAM_RDW_BYPASS_EN selects write-first collisions.
// Revision : 1.0 - initial release
// ============================================================================
module sram_dp_sync #(
    parameter int ADDR_WIDTH = 4,
    parameter int WORD_DEPTH = 16,
    parameter int WORD_WIDTH = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [WORD_WIDTH-1:0]   wr_data,
    input  logic [WORD_WIDTH/8-1:0] wr_be,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [WORD_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic                    init_busy
);

    localparam int                    c_LANES    = WORD_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0]   c_DEPTH    = (ADDR_WIDTH + 1)'(WORD_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] c_LAST     = ADDR_WIDTH'(WORD_DEPTH - 1);
    localparam logic [0:0]            c_ST_CLEAR = 1'b0;
    localparam logic [0:0]            c_ST_READY = 1'b1;

    logic [WORD_WIDTH-1:0] r_mem [WORD_DEPTH];
    logic [0:0]            r_state;
    logic [0:0]            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_clr_addr;
    logic                  w_clearing;
    logic                  w_wr_ok;
    logic                  w_rd_ok;
    logic                  w_rd_inrange;
    logic [WORD_WIDTH-1:0] w_rd_word;
    logic [WORD_WIDTH-1:0] r_s1_data;
    logic                  r_s1_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_CLEAR;
            r_clr_addr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_clearing) begin
                r_clr_addr <= r_clr_addr + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clearing  = 1'b0;
        init_busy   = 1'b0;
        if (r_state == c_ST_CLEAR) begin
            w_clearing = 1'b1;
            init_busy  = 1'b1;
            if (r_clr_addr == c_LAST) begin
                w_state_nxt = c_ST_READY;
            end
        end
    end

    // Out-of-range addresses are filtered here so they never alias into the array.
    assign w_wr_ok      = (r_state == c_ST_READY) && wr_en && ({1'b0, wr_addr} < c_DEPTH);
    assign w_rd_ok      = (r_state == c_ST_READY) && rd_en;
    assign w_rd_inrange = ({1'b0, rd_addr} < c_DEPTH);

    // The array itself is never reset; contents survive rst until the sweep reaches them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_clearing) begin
                r_mem[r_clr_addr] <= '0;
            end else if (w_wr_ok) begin
                for (int l = 0; l < c_LANES; l++) begin
                    if (wr_be[l]) begin
                        r_mem[wr_addr][8*l +: 8] <= wr_data[8*l +: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        w_rd_word = '0;
        if (w_rd_inrange) begin
            w_rd_word = r_mem[rd_addr];
`ifdef SRAM_RDW_BYPASS_EN
            if (w_wr_ok && (wr_addr == rd_addr)) begin
                for (int l = 0; l < c_LANES; l++) begin
                    if (wr_be[l]) begin
                        w_rd_word[8*l +: 8] = wr_data[8*l +: 8];
                    end
                end
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_data  <= '0;
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= w_rd_ok;
            if (w_rd_ok) begin
                r_s1_data <= w_rd_word;
            end
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic [WORD_WIDTH-1:0] r_s2_data;
            logic                  r_s2_valid;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_s2_data  <= '0;
                    r_s2_valid <= 1'b0;
                end else begin
                    r_s2_valid <= r_s1_valid;
                    if (r_s1_valid) begin
                        r_s2_data <= r_s1_data;
                    end
                end
            end

            assign rd_data  = r_s2_data;
            assign rd_valid = r_s2_valid;
        end else begin : g_lat1
            assign rd_data  = r_s1_data;
            assign rd_valid = r_s1_valid;
        end
    endgenerate

endmodule
`default_nettype wire

// File: doc/sram_dp_sync.md
Name: sram_dp_sync

Overview:
Parametrised simple-dual-port synchronous SRAM (one write port, one read port, single clock) with per-byte write enables, configurable read latency, and a built-in zero-clear sequencer that runs after reset. It is the general-purpose on-chip storage primitive for the SoC datapath. Register files, FIFOs and line buffers instantiate it directly.

Parameters:
addr_width, 4, address bits on both ports.
word_depth, 16, number of words; must be <= 2**addr_width.
word_width, 8, data bits per word; must be a multiple of 8.
rd_latency, 1, read latency in cycles; legal values 1 or 2 (2 adds an output register stage).

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
wr_en  input  1  write request, active-high.
wr_addr  input  addr_width  write address.
wr_data  input  word_width  write data.
wr_be  input  word_width/8  byte-lane enables; bit i covers wr_data[8i+7:8i].
rd_en  input  1  read request, active-high.
rd_addr  input  addr_width  read address.
rd_data  output  word_width  read data.
rd_valid  output  1  one-cycle pulse marking rd_data as new.
init_busy  output  1  high while the clear sequencer owns the array.

Behaviour:
- One clock (clk); reset rst is synchronous and active-high. No asynchronous paths and no # delays anywhere.
- Reset (rst=1 at an edge):
  - rd_data <= 0, rd_valid <= 0, and all read pipeline stages <= 0.
  - FSM <= CLEAR, clr_addr <= 0, init_busy = 1.
  - Array contents are not touched during rst.
- FSM states: CLEAR, READY.
  - CLEAR: each edge with rst=0 writes mem[clr_addr] <= 0 and increments clr_addr.
  - At the edge writing word_depth-1, the FSM moves to READY.
  - init_busy therefore stays 1 for exactly word_depth edges after rst deasserts, then is 0 from READY onward.
- Reset mid-clear: rst=1 restarts the sequence at address 0. rst=1 in READY re-enters CLEAR.
- While init_busy=1, wr_en and rd_en are ignored: no writes, and rd_valid stays 0.
- Write (READY):
  - wr_en=1 at an edge updates only the lanes of mem[wr_addr] whose wr_be bit is 1; other lanes keep their value.
  - wr_be=0 with wr_en=1 is a no-op.
  - wr_addr >= word_depth: write is dropped and no other address is affected.
- Read (READY):
  - rd_en=1 at edge k gives rd_data and rd_valid=1 at edge k+rd_latency.
  - rd_valid is high for one cycle per accepted read. Back-to-back reads give a continuous stream, one result per cycle.
  - rd_data holds its last value when rd_valid=0.
  - rd_addr >= word_depth returns 0 with rd_valid=1.
- Simultaneous read and write to the same address on the same edge: the result depends on SRAM_RDW_BYPASS_EN (see below). Different addresses never interact.
- Reads issued in the last CLEAR cycle are ignored. The first accepted read is the one sampled in READY.
- Width rules: lane count = word_width/8. Addresses are compared unsigned against word_depth.

Optional Feature:
Macro: SRAM_RDW_BYPASS_EN.
- Defined: write-first. On a same-address read and write, the read returns the merged word: lanes with wr_be=1 take wr_data, the other lanes take the old memory contents.
- Not defined: read-first. The read returns the old memory contents in full, and the new data is visible to reads from the next edge.
- In both cases the array update is identical.

Test Plan:
- Reset with word_depth=16: rst high 3 cycles then low → init_busy=1 for exactly 16 edges, then 0. A read of every address returns 0x00 with rd_valid one cycle after each rd_en.
- Byte lanes (word_width=32): write 0xAABBCCDD be=4'hF to addr 3, then 0x11223344 be=4'b0101 to addr 3, then read addr 3 → rd_data=0xAA22CC44.
- Latency (rd_latency=2): rd_en on edges k, k+1, k+2 to addrs 1, 2, 3 holding 0x10, 0x20, 0x30 → rd_valid high on edges k+2..k+4 with data 0x10, 0x20, 0x30 in order.
- Read/write collision on addr 5 (old 0x00, write 0x5A be=1) → 0x00 without SRAM_RDW_BYPASS_EN, 0x5A with it. A read on the next cycle returns 0x5A in both builds.
- Reset mid-clear: assert rst after 7 clear cycles, release → init_busy lasts a full 16 edges from the release. Writes attempted during busy are absent afterwards (reads return 0x00).
- Out-of-range (addr_width=4, word_depth=12): write 0xFF to addr 13 then read addr 13 → rd_data=0x00, rd_valid=1. Addrs 0..11 are unchanged.
